nrs_seq_server: RTL and testbench

- Responder on the NRS side of the channel-estimator interface; ch_est_top is the initiator.
- Receives the serial pseudo-random bit stream from the NRS Gold-sequence generator and packs it into QPSK bit pairs {nrs_r, nrs_i}.
- Stores the pairs in four symbol-group banks and answers the estimator's reads.
- Drives NRS_gen_ready per group and releases a bank on est_ack_nrs, so generation of later groups overlaps with estimation of earlier ones.

---
 rtl/nrs_seq_server.sv | 153 +++++++++++++++
 tb/tb_nrs_seq_server.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrs_seq_server.sv
// NRS sequence server: packs the serial Gold bit stream into QPSK {r,i} pairs, banks them
// in four symbol groups and serves the estimator. Optional status ports: NRS_SEQ_STATUS_EN.
module nrs_seq_server #(
    parameter int NRS_ADDR  = 4,
    parameter int GRP_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                gen_bit,
    input  logic                gen_valid,
    output logic                gen_ready,
    input  logic [1:0]          nrs_index_addr,
    input  logic [NRS_ADDR-1:0] rd_addr_nrs,
    input  logic                est_ack_nrs,
    output logic                nrs_r,
    output logic                nrs_i,
`ifdef NRS_SEQ_STATUS_EN
    output logic [3:0]          grp_loaded,
    output logic                nrs_overrun,
`endif
    output logic                NRS_gen_ready
);

    localparam int DEPTH = 1 << NRS_ADDR;
    localparam int NGRP  = 1 << GRP_SHIFT;
    localparam int GRP_W = NRS_ADDR - GRP_SHIFT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_buf [DEPTH];
    logic [NGRP-1:0]        r_loaded;
    logic [NGRP-1:0]        w_loaded_next;
    logic [NGRP-1:0]        w_set;
    logic [NGRP-1:0]        w_clr;
    logic [NRS_ADDR:0]      r_wr_cnt;
    logic [NRS_ADDR:0]      w_wr_cnt_next;
    logic                   r_bit_phase;
    logic                   r_even_bit;
    logic [GRP_SHIFT-1:0]   w_wg;
    logic                   w_done;
    logic                   w_gen_ready;
    logic                   w_xfer;
    logic                   w_pair_wr;
    logic                   w_grp_done;
    logic                   w_ack_hit;

    // The extra counter MSB marks a complete subframe; the pointer never wraps on its own.
    assign w_wg     = r_wr_cnt[NRS_ADDR-1 -: GRP_SHIFT];
    assign w_done   = r_wr_cnt[NRS_ADDR];

    // Holding off during frame_start keeps the generator's bit for the new subframe.
    assign w_gen_ready = (r_state == ST_FILL) & ~w_done & ~r_loaded[w_wg] & ~frame_start;
    assign w_xfer      = gen_valid & w_gen_ready;
    assign w_pair_wr   = w_xfer & r_bit_phase;
    assign w_grp_done  = w_pair_wr & (&r_wr_cnt[GRP_W-1:0]);
    assign w_ack_hit   = est_ack_nrs & r_loaded[nrs_index_addr];

    generate
        for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
            assign w_set[gi]         = w_grp_done & (w_wg == GRP_SHIFT'(gi));
            assign w_clr[gi]         = w_ack_hit & (nrs_index_addr == 2'(gi));
            assign w_loaded_next[gi] = ~frame_start & ((r_loaded[gi] & ~w_clr[gi]) | w_set[gi]);
        end
    endgenerate

    assign w_wr_cnt_next = frame_start ? '0 : r_wr_cnt + (NRS_ADDR+1)'(w_pair_wr);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (frame_start)
                    w_state_next = ST_FILL;
            end
            ST_FILL: begin
                if (frame_start)
                    w_state_next = ST_FILL;
                else if (&w_loaded_next)
                    w_state_next = ST_FULL;
                else if (w_wr_cnt_next[NRS_ADDR] && (w_loaded_next == '0))
                    w_state_next = ST_IDLE;
            end
            ST_FULL: begin
                if (frame_start)
                    w_state_next = ST_FILL;
                else if (w_wr_cnt_next[NRS_ADDR] && (w_loaded_next == '0))
                    w_state_next = ST_IDLE;
                else if (!w_wr_cnt_next[NRS_ADDR] && !(&w_loaded_next))
                    w_state_next = ST_FILL;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_loaded    <= '0;
            r_wr_cnt    <= '0;
            r_bit_phase <= 1'b0;
            r_even_bit  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_loaded <= w_loaded_next;
            r_wr_cnt <= w_wr_cnt_next;
            if (frame_start)
                r_bit_phase <= 1'b0;
            else if (w_xfer)
                r_bit_phase <= ~r_bit_phase;
            if (w_xfer && !r_bit_phase)
                r_even_bit <= gen_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++)
                r_buf[k] <= 2'b00;
        end else if (w_pair_wr) begin
            r_buf[r_wr_cnt[NRS_ADDR-1:0]] <= {r_even_bit, gen_bit};
        end
    end

    assign gen_ready     = w_gen_ready;
    assign nrs_r         = r_buf[rd_addr_nrs][1];
    assign nrs_i         = r_buf[rd_addr_nrs][0];
    assign NRS_gen_ready = r_loaded[nrs_index_addr];

`ifdef NRS_SEQ_STATUS_EN
    logic r_overrun;

    // Sticky until the next subframe so a late or stray ack is visible to software.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_overrun <= 1'b0;
        else if (frame_start)
            r_overrun <= 1'b0;
        else if (est_ack_nrs && !r_loaded[nrs_index_addr])
            r_overrun <= 1'b1;
    end

    assign grp_loaded  = r_loaded;
    assign nrs_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_nrs_seq_server.sv
// Bench for nrs_seq_server: table vectors, directed corner sequences and random traffic
// checked against a pair/group level reference model.
module tb_nrs_seq_server;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       gen_bit;
    logic       gen_valid;
    logic       gen_ready;
    logic [1:0] nrs_index_addr;
    logic [3:0] rd_addr_nrs;
    logic       est_ack_nrs;
    logic       nrs_r;
    logic       nrs_i;
    logic       NRS_gen_ready;
`ifdef NRS_SEQ_STATUS_EN
    logic [3:0] grp_loaded;
    logic       nrs_overrun;
`endif

    always #5 clk = ~clk;

    nrs_seq_server #(.NRS_ADDR(4), .GRP_SHIFT(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .gen_bit        (gen_bit),
        .gen_valid      (gen_valid),
        .gen_ready      (gen_ready),
        .nrs_index_addr (nrs_index_addr),
        .rd_addr_nrs    (rd_addr_nrs),
        .est_ack_nrs    (est_ack_nrs),
        .nrs_r          (nrs_r),
        .nrs_i          (nrs_i),
`ifdef NRS_SEQ_STATUS_EN
        .grp_loaded     (grp_loaded),
        .nrs_overrun    (nrs_overrun),
`endif
        .NRS_gen_ready  (NRS_gen_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: bit count of the subframe, pair memory, group flags.
    bit [1:0] m_mem [16];
    bit       m_loaded [4];
    int       m_nbits;
    bit       m_active;
    bit       m_stage;
    bit       m_ovr;
    bit       m_gr;

    typedef struct {
        logic       fs, gv, gb;
        logic [1:0] ix;
        logic [3:0] ra;
        logic       ak;
        logic       e_gr, e_ngr, e_r, e_i;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(input logic fs, input logic gv, input logic gb,
                                input logic [1:0] ix, input logic [3:0] ra, input logic ak,
                                input logic egr, input logic engr, input logic er, input logic ei);
        vec_t v;
        v.fs = fs; v.gv = gv; v.gb = gb; v.ix = ix; v.ra = ra; v.ak = ak;
        v.e_gr = egr; v.e_ngr = engr; v.e_r = er; v.e_i = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic m_reset();
        for (int k = 0; k < 16; k++) m_mem[k] = 2'b00;
        for (int g = 0; g < 4; g++) m_loaded[g] = 1'b0;
        m_nbits  = 0;
        m_active = 1'b0;
        m_stage  = 1'b0;
        m_ovr    = 1'b0;
    endtask

    function automatic bit m_any_loaded();
        bit a = 1'b0;
        for (int g = 0; g < 4; g++) a |= m_loaded[g];
        return a;
    endfunction

    // Drive one cycle's inputs and compare every output against the model before the edge.
    task automatic drive(input logic fs, input logic gv, input logic gb,
                         input logic [1:0] ix, input logic [3:0] ra, input logic ak);
        frame_start = fs; gen_valid = gv; gen_bit = gb;
        nrs_index_addr = ix; rd_addr_nrs = ra; est_ack_nrs = ak;
        #1;
        m_gr = m_active && !fs && (m_nbits < 32) && !m_loaded[m_nbits / 8];
        check("gen_ready", gen_ready, m_gr);
        check("NRS_gen_ready", NRS_gen_ready, m_loaded[ix]);
        check("nrs_r", nrs_r, m_mem[ra][1]);
        check("nrs_i", nrs_i, m_mem[ra][0]);
`ifdef NRS_SEQ_STATUS_EN
        check("nrs_overrun", nrs_overrun, m_ovr);
        for (int g = 0; g < 4; g++) check("grp_loaded", grp_loaded[g], m_loaded[g]);
`endif
    endtask

    task automatic tick();
        int p;
        @(posedge clk);
        if (frame_start) begin
            for (int g = 0; g < 4; g++) m_loaded[g] = 1'b0;
            m_nbits  = 0;
            m_active = 1'b1;
            m_ovr    = 1'b0;
        end else begin
            if (est_ack_nrs) begin
                if (m_loaded[nrs_index_addr]) m_loaded[nrs_index_addr] = 1'b0;
                else m_ovr = 1'b1;
            end
            if (gen_valid && m_gr) begin
                if (m_nbits % 2 == 0) begin
                    m_stage = gen_bit;
                end else begin
                    p = m_nbits / 2;
                    m_mem[p] = {m_stage, gen_bit};
                    if (p % 4 == 3) m_loaded[p / 4] = 1'b1;
                    $display("pair %0d written: r=%b i=%b", p, m_stage, gen_bit);
                end
                m_nbits++;
            end
            if (m_active && m_nbits == 32 && !m_any_loaded()) m_active = 1'b0;
        end
        #1;
    endtask

    task automatic step(input logic fs, input logic gv, input logic gb,
                        input logic [1:0] ix, input logic [3:0] ra, input logic ak);
        drive(fs, gv, gb, ix, ra, ak);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [1:0] exp_e [4];

        rst = 1'b0; frame_start = 1'b0; gen_bit = 1'b0; gen_valid = 1'b0;
        nrs_index_addr = 2'd0; rd_addr_nrs = 4'd0; est_ack_nrs = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // First group: bits 1,0,0,1,1,1,0,0 -> entries 10, 01, 11, 00.
        tbl[0]  = mk(1, 0, 0, 2'd0, 4'd0, 0,  0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 2'd0, 4'd0, 0,  1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 2'd0, 4'd0, 0,  1, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 2'd0, 4'd0, 0,  1, 0, 1, 0);
        tbl[4]  = mk(0, 1, 1, 2'd0, 4'd0, 0,  1, 0, 1, 0);
        tbl[5]  = mk(0, 1, 1, 2'd0, 4'd0, 0,  1, 0, 1, 0);
        tbl[6]  = mk(0, 1, 1, 2'd0, 4'd0, 0,  1, 0, 1, 0);
        tbl[7]  = mk(0, 1, 0, 2'd0, 4'd0, 0,  1, 0, 1, 0);
        tbl[8]  = mk(0, 1, 0, 2'd0, 4'd0, 0,  1, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 2'd0, 4'd2, 0,  1, 1, 1, 1);
        tbl[10] = mk(0, 0, 0, 2'd0, 4'd1, 0,  1, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 2'd0, 4'd3, 0,  1, 1, 0, 0);
        tbl[12] = mk(0, 0, 0, 2'd1, 4'd0, 0,  1, 0, 1, 0);
        for (int v = 0; v < 13; v++) begin
            drive(tbl[v].fs, tbl[v].gv, tbl[v].gb, tbl[v].ix, tbl[v].ra, tbl[v].ak);
            check($sformatf("vec%0d.gen_ready", v), gen_ready, tbl[v].e_gr);
            check($sformatf("vec%0d.NRS_gen_ready", v), NRS_gen_ready, tbl[v].e_ngr);
            check($sformatf("vec%0d.nrs_r", v), nrs_r, tbl[v].e_r);
            check($sformatf("vec%0d.nrs_i", v), nrs_i, tbl[v].e_i);
            tick();
        end

        // Fill the rest of the subframe without acks; a 33rd bit must be held off.
        for (int n = 0; n < 24; n++) step(0, 1, 1'($urandom), 2'd0, 4'd0, 0);
        for (int n = 0; n < 3; n++) begin
            drive(0, 1, 1, 2'd0, 4'd0, 0);
            check("full.hold_bit33", gen_ready, 1'b0);
            tick();
        end
        for (int g = 0; g < 4; g++) begin
            drive(0, 0, 0, 2'(g), 4'd0, 0);
            check("full.NRS_gen_ready", NRS_gen_ready, 1'b1);
            tick();
        end
        for (int k = 0; k < 16; k++) step(0, 0, 0, 2'd0, 4'(k), 0);

        // Ack group 1: flag falls the cycle after the pulse; others stay loaded.
        drive(0, 0, 0, 2'd1, 4'd0, 1);
        check("ack1.pulse_cycle", NRS_gen_ready, 1'b1);
        tick();
        drive(0, 0, 0, 2'd1, 4'd0, 0);
        check("ack1.fall", NRS_gen_ready, 1'b0);
        tick();
        drive(0, 0, 0, 2'd2, 4'd0, 0);
        check("ack1.grp2_kept", NRS_gen_ready, 1'b1);
        tick();
        step(0, 0, 0, 2'd0, 4'd0, 1);
        step(0, 0, 0, 2'd2, 4'd0, 1);
        step(0, 0, 0, 2'd3, 4'd0, 1);
        for (int n = 0; n < 2; n++) begin
            drive(0, 1, 1, 2'(n), 4'd0, 0);
            check("idle.gen_ready", gen_ready, 1'b0);
            check("idle.NRS_gen_ready", NRS_gen_ready, 1'b0);
            tick();
        end

        // Partial group aborted by frame_start; group 0 then holds only the new bits.
        step(1, 0, 0, 2'd0, 4'd0, 0);
        for (int n = 0; n < 7; n++) step(0, 1, 1, 2'd0, 4'd0, 0);
        step(1, 0, 0, 2'd0, 4'd0, 0);
        pat = 8'b11000110;
        for (int n = 0; n < 8; n++) step(0, 1, pat[n], 2'd0, 4'd0, 0);
        exp_e[0] = 2'b01; exp_e[1] = 2'b10; exp_e[2] = 2'b00; exp_e[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 2'(k), 4'(k), 0);
            check("restart.nrs_r", nrs_r, exp_e[k][1]);
            check("restart.nrs_i", nrs_i, exp_e[k][0]);
            check("restart.NRS_gen_ready", NRS_gen_ready, (k == 0));
            tick();
        end

        // Ack of an unloaded group changes nothing (overrun flag when present).
        drive(0, 0, 0, 2'd3, 4'd0, 1);
        check("ack_unloaded.pulse", NRS_gen_ready, 1'b0);
        tick();
        drive(0, 0, 0, 2'd3, 4'd0, 0);
        check("ack_unloaded.after", NRS_gen_ready, 1'b0);
        check("ack_unloaded.gen_ready", gen_ready, 1'b1);
`ifdef NRS_SEQ_STATUS_EN
        check("ack_unloaded.overrun", nrs_overrun, 1'b1);
`endif
        tick();

        // Asynchronous reset mid-FILL with groups 0 and 1 loaded.
        for (int n = 0; n < 8; n++) step(0, 1, 1'($urandom), 2'd0, 4'd0, 0);
        drive(0, 1, 1, 2'd1, 4'd1, 0);
        #1 rst = 1'b0;
        #1;
        check("async_rst.gen_ready", gen_ready, 1'b0);
        check("async_rst.NRS_gen_ready", NRS_gen_ready, 1'b0);
        check("async_rst.nrs_r", nrs_r, 1'b0);
        check("async_rst.nrs_i", nrs_i, 1'b0);
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(0, 1, 1, 2'd0, 4'd0, 0);
            check("post_rst.idle", gen_ready, 1'b0);
            tick();
        end
        step(1, 0, 0, 2'd0, 4'd0, 0);
        drive(0, 1, 1, 2'd0, 4'd0, 0);
        check("post_rst.fill", gen_ready, 1'b1);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            logic fs;
            fs = ($urandom_range(63) == 0) || (!m_active && ($urandom_range(3) == 0));
            step(fs, ($urandom_range(3) != 0), 1'($urandom), 2'($urandom), 4'($urandom),
                 ($urandom_range(5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
